// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM
// states, and the alignment check used at instruction acceptance.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} lsu_state_t;
    typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE} lsu_op_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Encodings that have no meaning for the given access direction.
    function automatic logic is_unsupported(input logic load, input logic store,
                                            input logic [2:0] funct3);
        return (load && store) ||
               (load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) ||
               (store && (funct3 >= 3'b011));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/gnt/rvalid bus between the load/store unit (master) and memory (slave).
interface lsu_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DWIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store enables/replicated data and load extraction with
// sign or zero extension. Purely combinational, fixed at four 8-bit lanes.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DWIDTH-1:0] storedata,
    input  logic [DWIDTH-1:0] rdata,
    output logic [3:0]        be,
    output logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] load_data
);

    logic [DWIDTH-1:0] shifted;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be    = 4'b1111;
        wdata = storedata;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{storedata[7:0]}};
                end
                2'b01: begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{storedata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_data = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: accepts one instruction at a time from execute, runs the data
// memory handshake for loads/stores, and drives the register-file writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] storedata_i,
    input  logic [4:0]        rd_i,
    input  logic              regwren_i,
    output logic              stall_o,
    lsu_if.master             mem,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [DWIDTH-1:0] wb_data_o,
    output logic              wb_regwren_o,
    output logic              fault_o
);

    lsu_state_t        state, state_next;
    lsu_op_t           op_q;
    logic [AWIDTH-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DWIDTH-1:0] storedata_q;
    logic [4:0]        rd_q;
    logic              regwren_q;

    logic              accept, fault_in, in_req;
    logic              wb_fire, wb_regwren_next, fault_next;
    logic [4:0]        wb_rd_next;
    logic [DWIDTH-1:0] wb_data_next;
    logic [3:0]        lane_be;
    logic [DWIDTH-1:0] lane_wdata, load_data;

    assign accept   = (state == IDLE) && valid_i;
    assign fault_in = is_unsupported(memren_i, memwren_i, funct3_i) ||
                      ((memren_i || memwren_i) && is_misaligned(funct3_i, addr_i[1:0]));
    assign stall_o  = (state != IDLE);
    assign in_req   = (state == REQ);

    lsu_align #(.DWIDTH(DWIDTH)) u_align (
        .is_store  (op_q == OP_STORE),
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .storedata (storedata_q),
        .rdata     (mem.mem_rdata_i),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    // Bus outputs are qualified by REQ so an async reset drops them at once.
    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req && (op_q == OP_STORE);
    assign mem.mem_addr_o  = in_req ? {addr_q[AWIDTH-1:2], 2'b00} : '0;
    assign mem.mem_be_o    = in_req ? lane_be : 4'b0000;
    assign mem.mem_wdata_o = in_req ? lane_wdata : '0;

    always_comb begin
        state_next      = state;
        wb_fire         = 1'b0;
        wb_rd_next      = rd_q;
        wb_data_next    = addr_q;
        wb_regwren_next = 1'b0;
        fault_next      = 1'b0;
        case (state)
            IDLE: if (valid_i) begin
                wb_rd_next   = rd_i;
                wb_data_next = addr_i;
                if (fault_in) begin
                    wb_fire    = 1'b1;
                    fault_next = 1'b1;
                end else if (!memren_i && !memwren_i) begin
                    wb_fire         = 1'b1;
                    wb_regwren_next = regwren_i && (rd_i != 5'd0);
                end else begin
                    state_next = REQ;
                end
            end
            REQ: if (mem.mem_gnt_i) begin
                if (op_q == OP_STORE) begin
                    wb_fire    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: if (mem.mem_rvalid_i) begin
                wb_fire         = 1'b1;
                wb_data_next    = load_data;
                wb_regwren_next = (rd_q != 5'd0);
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= OP_ALU;
            addr_q       <= '0;
            funct3_q     <= '0;
            storedata_q  <= '0;
            rd_q         <= '0;
            regwren_q    <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            wb_regwren_o <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            state        <= state_next;
            wb_valid_o   <= wb_fire;
            wb_regwren_o <= wb_regwren_next;
            fault_o      <= fault_next;
            if (wb_fire) begin
                wb_rd_o   <= wb_rd_next;
                wb_data_o <= wb_data_next;
            end
            if (accept) begin
                op_q        <= memren_i ? OP_LOAD : (memwren_i ? OP_STORE : OP_ALU);
                addr_q      <= addr_i;
                funct3_q    <= funct3_i;
                storedata_q <= storedata_i;
                rd_q        <= rd_i;
                regwren_q   <= regwren_i;
            end
        end
    end

    // regwren is captured for completeness; load writeback is gated by rd alone.
    logic unused_regwren;
    assign unused_regwren = regwren_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected writebacks
// into a queue and a negedge monitor pops and compares each wb_valid pulse.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        regwren;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, memren_i, memwren_i, regwren_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, storedata_i;
    logic [4:0]  rd_i;
    logic        stall_o, wb_valid_o, wb_regwren_o, fault_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    lsu_if #(.AWIDTH(32), .DWIDTH(32)) mem_bus ();

    load_store_unit #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .memren_i     (memren_i),
        .memwren_i    (memwren_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .storedata_i  (storedata_i),
        .rd_i         (rd_i),
        .regwren_i    (regwren_i),
        .stall_o      (stall_o),
        .mem          (mem_bus),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_regwren_o (wb_regwren_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input logic chk,
                             input logic rw, input logic flt);
        exp_t e;
        e.rd = rd; e.data = data; e.chk_data = chk; e.regwren = rw; e.fault = flt;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; the DUT accepts at the following edge.
    task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        valid_i = 1'b1; memren_i = ren; memwren_i = wen; funct3_i = f3;
        addr_i = a; storedata_i = sd; rd_i = rd; regwren_i = rw;
        @(posedge clk); #1;
        valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
    endtask

    task automatic check_bus(input logic [31:0] a, input logic [3:0] be,
                             input logic chk_wdata, input logic [31:0] wd, input logic we);
        check("bus_req", mem_bus.mem_req_o, 1);
        check("bus_stall", stall_o, 1);
        check("bus_addr", mem_bus.mem_addr_o, a);
        check("bus_be", mem_bus.mem_be_o, be);
        check("bus_we", mem_bus.mem_we_o, we);
        if (chk_wdata) check("bus_wdata", mem_bus.mem_wdata_o, wd);
    endtask

    task automatic handshake(input int gnt_dly, input logic is_load, input int rv_dly,
                             input logic [31:0] rdata);
        for (int i = 0; i < gnt_dly; i++) begin
            check("req_held", mem_bus.mem_req_o, 1);
            @(posedge clk); #1;
        end
        check("req_at_gnt", mem_bus.mem_req_o, 1);
        mem_bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt_i = 1'b0;
        if (is_load) begin
            for (int i = 0; i < rv_dly; i++) begin
                check("stall_wait", stall_o, 1);
                check("req_dropped", mem_bus.mem_req_o, 0);
                @(posedge clk); #1;
            end
            mem_bus.mem_rvalid_i = 1'b1;
            mem_bus.mem_rdata_i  = rdata;
            @(posedge clk); #1;
            mem_bus.mem_rvalid_i = 1'b0;
            mem_bus.mem_rdata_i  = '0;
        end
        check("stall_done", stall_o, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", wb_valid_o, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", wb_rd_o, e.rd);
                if (e.chk_data) check("wb_data", wb_data_o, e.data);
                check("wb_regwren", wb_regwren_o, e.regwren);
                check("wb_fault", fault_o, e.fault);
            end
        end else if (!rst && fault_o) begin
            check("fault_without_wb", fault_o, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        valid_i = 0; memren_i = 0; memwren_i = 0; regwren_i = 0;
        funct3_i = 0; addr_i = 0; storedata_i = 0; rd_i = 0;
        mem_bus.mem_gnt_i = 0; mem_bus.mem_rvalid_i = 0; mem_bus.mem_rdata_i = 0;
        #12;
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_req", mem_bus.mem_req_o, 0);
        check("rst_be", mem_bus.mem_be_o, 0);
        check("rst_fault", fault_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Non-memory op: one-cycle writeback, no stall.
        expect_wb(5'd5, 32'h0000_1234, 1, 1, 0);
        check("alu_stall_pre", stall_o, 0);
        issue(0, 0, F3_W, 32'h1234, 0, 5'd5, 1);
        check("alu_stall", stall_o, 0);

        // LB 0x103: gnt after 2 waits, rvalid after 3 waits.
        expect_wb(5'd6, 32'hFFFF_FF80, 1, 1, 0);
        issue(1, 0, F3_B, 32'h103, 0, 5'd6, 1);
        check_bus(32'h100, 4'b1111, 0, 0, 0);
        handshake(2, 1, 3, 32'h80FF_0000);

        // LHU / LH at 0x102.
        expect_wb(5'd7, 32'h0000_BEEF, 1, 1, 0);
        issue(1, 0, F3_HU, 32'h102, 0, 5'd7, 1);
        check_bus(32'h100, 4'b1111, 0, 0, 0);
        handshake(0, 1, 0, 32'hBEEF_1234);
        expect_wb(5'd8, 32'hFFFF_BEEF, 1, 1, 0);
        issue(1, 0, F3_H, 32'h102, 0, 5'd8, 1);
        handshake(1, 1, 1, 32'hBEEF_1234);

        // Stores: lane enables and replicated data.
        expect_wb(5'd9, 0, 0, 0, 0);
        issue(0, 1, F3_B, 32'h101, 32'hAABB_CCDD, 5'd9, 0);
        check_bus(32'h100, 4'b0010, 1, 32'hDDDD_DDDD, 1);
        handshake(1, 0, 0, 0);
        expect_wb(5'd9, 0, 0, 0, 0);
        issue(0, 1, F3_H, 32'h102, 32'h1122_3344, 5'd9, 0);
        check_bus(32'h100, 4'b1100, 1, 32'h3344_3344, 1);
        handshake(0, 0, 0, 0);
        expect_wb(5'd9, 0, 0, 0, 0);
        issue(0, 1, F3_W, 32'h104, 32'hCAFE_BABE, 5'd9, 0);
        check_bus(32'h104, 4'b1111, 1, 32'hCAFE_BABE, 1);
        handshake(0, 0, 0, 0);

        // Faults: misaligned word, bad load/store funct3, load+store together.
        expect_wb(5'd10, 0, 0, 0, 1);
        issue(1, 0, F3_W, 32'h102, 0, 5'd10, 1);
        check("fault_no_req", mem_bus.mem_req_o, 0);
        check("fault_no_stall", stall_o, 0);
        expect_wb(5'd10, 0, 0, 0, 1);
        issue(1, 0, 3'b011, 32'h0, 0, 5'd10, 1);
        check("fault_f3_no_req", mem_bus.mem_req_o, 0);
        expect_wb(5'd10, 0, 0, 0, 1);
        issue(0, 1, 3'b011, 32'h0, 0, 5'd10, 0);
        expect_wb(5'd10, 0, 0, 0, 1);
        issue(1, 1, F3_W, 32'h0, 0, 5'd10, 1);

        // rd=0: data still reported, write enable suppressed.
        expect_wb(5'd0, 32'h0000_0055, 1, 0, 0);
        issue(0, 0, F3_W, 32'h55, 0, 5'd0, 1);
        expect_wb(5'd11, 32'h0000_0080, 1, 1, 0);
        issue(1, 0, F3_BU, 32'h101, 0, 5'd11, 1);
        handshake(0, 1, 0, 32'h0000_8000);
        expect_wb(5'd0, 32'h1234_5678, 1, 0, 0);
        issue(1, 0, F3_W, 32'h10, 0, 5'd0, 1);
        handshake(0, 1, 0, 32'h1234_5678);

        // Reset while waiting for read data aborts the load.
        issue(1, 0, F3_W, 32'h300, 0, 5'd3, 1);
        mem_bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt_i = 1'b0;
        check("abort_in_wait", stall_o, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_req", mem_bus.mem_req_o, 0);
        check("abort_stall", stall_o, 0);
        check("abort_wb_data", wb_data_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_bus.mem_rvalid_i = 1'b1;
        mem_bus.mem_rdata_i  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_bus.mem_rvalid_i = 1'b0;
        check("abort_no_wb", wb_valid_o, 0);
        check("abort_idle", stall_o, 0);

        expect_wb(5'd12, 32'hDEAD_BEEF, 1, 1, 0);
        issue(1, 0, F3_W, 32'h200, 0, 5'd12, 1);
        check_bus(32'h200, 4'b1111, 0, 0, 0);
        handshake(1, 1, 2, 32'hDEAD_BEEF);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
